// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Elastic pipeline-stage register. It carries a control field and a data
//   field through a main + skid buffer with a valid/ready handshake. Flush
//   discards held entries and inserts a bubble. A saturating counter records
//   the cycles on which downstream was ready but no entry was offered.
//
//   state | meaning
//   ------+-----------------------------------------
//   EMPTY | main and skid invalid
//   ONE   | main valid, skid empty
//   FULL  | main and skid valid, upstream is stalled
//
// Ports
//   Clk, Reset         clock and asynchronous active-high reset
//   InValid/InReady    upstream handshake; InReady is registered (skid empty)
//   InCtrl, InData     upstream control and data fields
//   Flush              drop every held entry and the entry offered this cycle
//   OutValid/OutReady  downstream handshake
//   OutCtrl, OutData   main entry; OutCtrl reads as 0 (NOP) when invalid
//   Occupancy          number of valid entries, 0..2
//   BubbleCount        saturating count of cycles with OutReady=1 and OutValid=0
module pipe_stage_buffer #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  BubbleCount
);

    // Bit 0 is the main valid bit and bit 1 is the skid valid bit, so the
    // state register is the pair of valid flags.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  bubble_count;

    logic main_valid;
    logic skid_valid;
    logic xfer_in;
    logic xfer_out;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // Ready comes from registered state only, so downstream stalls never
    // form a combinational path back upstream; the skid entry absorbs the
    // transfer already in flight.
    assign InReady  = ~skid_valid;
    assign xfer_in  = InValid & InReady;
    assign xfer_out = main_valid & OutReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= EMPTY;
            main_ctrl    <= '0;
            main_data    <= '0;
            skid_ctrl    <= '0;
            skid_data    <= '0;
            bubble_count <= '0;
        end else begin
            // Bubbles count regardless of Flush.
            if (OutReady && !main_valid && bubble_count != CNT_MAX)
                bubble_count <= bubble_count + CNT_W'(1);

            if (Flush) begin
                // Data fields are left as they are; only valid and control
                // are cleared, which is enough to make both entries NOPs.
                state     <= EMPTY;
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (xfer_in) begin
                            state     <= ONE;
                            main_ctrl <= InCtrl;
                            main_data <= InData;
                        end
                    end
                    ONE: begin
                        case ({xfer_in, xfer_out})
                            2'b11: begin
                                main_ctrl <= InCtrl;
                                main_data <= InData;
                            end
                            2'b10: begin
                                state     <= FULL;
                                skid_ctrl <= InCtrl;
                                skid_data <= InData;
                            end
                            2'b01: begin
                                state     <= EMPTY;
                                main_ctrl <= '0;
                            end
                            default: ;
                        endcase
                    end
                    FULL: begin
                        if (xfer_out) begin
                            state     <= ONE;
                            main_ctrl <= skid_ctrl;
                            main_data <= skid_data;
                            skid_ctrl <= '0;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign OutValid    = main_valid;
    assign OutCtrl     = main_valid ? main_ctrl : '0;
    assign OutData     = main_data;
    assign Occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};
    assign BubbleCount = bubble_count;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 3;

    logic              Clk;
    logic              Reset;
    logic              InValid;
    logic              InReady;
    logic [CTRL_W-1:0] InCtrl;
    logic [DATA_W-1:0] InData;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [CTRL_W-1:0] OutCtrl;
    logic [DATA_W-1:0] OutData;
    logic [1:0]        Occupancy;
    logic [CNT_W-1:0]  BubbleCount;

    int checks = 0;
    int errors = 0;

    pipe_stage_buffer #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InValid    (InValid),
        .InReady    (InReady),
        .InCtrl     (InCtrl),
        .InData     (InData),
        .Flush      (Flush),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutCtrl    (OutCtrl),
        .OutData    (OutData),
        .Occupancy  (Occupancy),
        .BubbleCount(BubbleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [CTRL_W-1:0] oc,
                             input logic [DATA_W-1:0] od, input logic ir, input logic [1:0] occ,
                             input logic [CNT_W-1:0] bub);
        chk({tag, ".OutValid"},    64'(OutValid),    64'(ov));
        chk({tag, ".OutCtrl"},     64'(OutCtrl),     64'(oc));
        chk({tag, ".OutData"},     64'(OutData),     64'(od));
        chk({tag, ".InReady"},     64'(InReady),     64'(ir));
        chk({tag, ".Occupancy"},   64'(Occupancy),   64'(occ));
        chk({tag, ".BubbleCount"}, 64'(BubbleCount), 64'(bub));
    endtask

    logic [DATA_W-1:0] q[$];
    int                bub_m;
    int                next_id;
    logic [CTRL_W-1:0] exp_ctrl;
    int                sz;

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        InCtrl   = '0;
        InData   = '0;
        Flush    = 1'b0;
        OutReady = 1'b0;
        #12;
        chk_state("reset", 1'b0, 16'h0, 32'd0, 1'b1, 2'd0, 3'd0);
        Reset = 1'b0;

        // Streaming: first entry lands while OutReady=0 so no bubble is seen.
        InValid = 1'b1; InCtrl = 16'h00A5; InData = 32'd1; OutReady = 1'b0;
        tick();
        chk_state("stream1", 1'b1, 16'h00A5, 32'd1, 1'b1, 2'd1, 3'd0);
        OutReady = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            InData = DATA_W'(i);
            tick();
            chk_state($sformatf("stream%0d", i), 1'b1, 16'h00A5, DATA_W'(i), 1'b1, 2'd1, 3'd0);
        end
        InValid = 1'b0;
        tick();
        chk_state("stream_drain", 1'b0, 16'h0, 32'd4, 1'b1, 2'd0, 3'd0);
        OutReady = 1'b0;

        // Back-pressure
        InValid = 1'b1; InCtrl = 16'h0011; InData = 32'd10;
        tick();
        chk_state("bp_10", 1'b1, 16'h0011, 32'd10, 1'b1, 2'd1, 3'd0);
        InData = 32'd11;
        tick();
        chk_state("bp_11", 1'b1, 16'h0011, 32'd10, 1'b0, 2'd2, 3'd0);
        InData = 32'd12;
        tick();
        chk_state("bp_12_rejected", 1'b1, 16'h0011, 32'd10, 1'b0, 2'd2, 3'd0);
        OutReady = 1'b1;
        tick();
        chk_state("bp_rel1", 1'b1, 16'h0011, 32'd11, 1'b1, 2'd1, 3'd0);
        tick();
        chk_state("bp_rel2", 1'b1, 16'h0011, 32'd12, 1'b1, 2'd1, 3'd0);
        InValid = 1'b0;
        tick();
        chk_state("bp_rel3", 1'b0, 16'h0, 32'd12, 1'b1, 2'd0, 3'd0);
        OutReady = 1'b0;

        // Flush from FULL with an offer in the same cycle
        InValid = 1'b1; InCtrl = 16'h0022; InData = 32'd20;
        tick();
        InData = 32'd21;
        tick();
        chk_state("fl_full", 1'b1, 16'h0022, 32'd20, 1'b0, 2'd2, 3'd0);
        InData = 32'd22; Flush = 1'b1;
        tick();
        chk_state("flush", 1'b0, 16'h0, 32'd20, 1'b1, 2'd0, 3'd0);
        Flush = 1'b0; InValid = 1'b0;

        // Bubble counter saturation; 22 must never show up.
        OutReady = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_state($sformatf("bubble%0d", i), 1'b0, 16'h0, 32'd20, 1'b1, 2'd0,
                      CNT_W'((i > 7) ? 7 : i));
        end

        // Flush together with a downstream transfer
        OutReady = 1'b0; InValid = 1'b1; InCtrl = 16'h0030; InData = 32'd30;
        tick();
        chk_state("fo_load", 1'b1, 16'h0030, 32'd30, 1'b1, 2'd1, 3'd7);
        InValid = 1'b0; OutReady = 1'b1; Flush = 1'b1;
        tick();
        chk_state("fo_flush", 1'b0, 16'h0, 32'd30, 1'b1, 2'd0, 3'd7);
        Flush = 1'b0; OutReady = 1'b0;

        // Asynchronous reset mid-cycle while FULL
        InValid = 1'b1; InCtrl = 16'h0040; InData = 32'd40;
        tick();
        InData = 32'd41;
        tick();
        chk_state("ar_full", 1'b1, 16'h0040, 32'd40, 1'b0, 2'd2, 3'd7);
        #2;
        Reset = 1'b1;
        #1;
        chk_state("ar_async", 1'b0, 16'h0, 32'd0, 1'b1, 2'd0, 3'd0);
        Reset = 1'b0;
        InData = 32'd50; InCtrl = 16'h0050; OutReady = 1'b1;
        tick();
        chk_state("ar_after", 1'b1, 16'h0050, 32'd50, 1'b1, 2'd1, 3'd1);

        // Random stress against a queue scoreboard
        InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        q.delete();
        bub_m   = 0;
        next_id = 100;
        for (int c = 0; c < 300; c++) begin
            sz = q.size();
            chk("rs.OutValid",  64'(OutValid),  64'(sz > 0));
            chk("rs.Occupancy", 64'(Occupancy), 64'(sz));
            chk("rs.InReady",   64'(InReady),   64'(sz < 2));
            chk("rs.Bubble",    64'(BubbleCount), 64'(bub_m));
            if (sz > 0) begin
                exp_ctrl = CTRL_W'(q[0]) | 16'h8000;
                chk("rs.OutData", 64'(OutData), 64'(q[0]));
            end else begin
                exp_ctrl = '0;
            end
            chk("rs.OutCtrl", 64'(OutCtrl), 64'(exp_ctrl));

            InValid  = ($urandom_range(0, 99) < 70);
            OutReady = ($urandom_range(0, 99) < 60);
            Flush    = ($urandom_range(0, 99) < 5);
            InData   = DATA_W'(next_id);
            InCtrl   = CTRL_W'(next_id) | 16'h8000;

            if (OutReady && sz == 0 && bub_m < 7) bub_m++;
            if (Flush) begin
                q.delete();
            end else begin
                if (OutReady && sz > 0) void'(q.pop_front());
                if (InValid && sz < 2) begin
                    q.push_back(DATA_W'(next_id));
                    next_id++;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
